// File: rtl/spi_target.sv
// SPI target endpoint: oversamples SCLK/CS_N/MOSI in the clk_i domain, deserialises MOSI into
// rx words and serialises tx words from a one-deep holding register onto MISO.
module spi_target #(
  parameter int unsigned       DATA_W      = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_underrun_o,
  output logic              frame_abort_o
);

  localparam int unsigned CntW    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int unsigned SettleW = $clog2(SYNC_STAGES + 2);
  localparam logic [CntW-1:0]    LastBit   = CntW'(DATA_W - 1);
  localparam logic [SettleW-1:0] SettleMax = SettleW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {StWaitDesel, StIdle, StActive} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [SettleW-1:0]     settle_q, settle_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   abort_q, abort_d;

  logic sclk_s, cs_s, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  logic reload;
  logic [DATA_W-1:0] rx_word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign lead_edge   = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q && !cs_s;
  assign cs_rise     = !cs_prev_q && cs_s;
  assign rx_word     = {rx_shift_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    reload      = 1'b0;

    unique case (state_q)
      // Let the synchronisers flush real pin levels before trusting cs_n, so a frame
      // already in progress at reset is never rejoined.
      StWaitDesel: begin
        if (settle_q != SettleMax) begin
          settle_d = settle_q + SettleW'(1);
        end else if (cs_s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (cs_fall) begin
          state_d   = StActive;
          bit_cnt_d = '0;
          reload    = 1'b1;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d    = StIdle;
          abort_d    = (bit_cnt_q != '0);
          bit_cnt_d  = '0;
          tx_shift_d = '0;
        end else if (sample_edge) begin
          rx_shift_d = rx_word[DATA_W-2:0];
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            reload     = CPHA;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (shift_edge) begin
          // bit_cnt == 0 on a shift edge marks a word boundary: reload (CPHA=0) or hold
          // the MSB that is already on MISO (CPHA=1).
          if (!CPHA && (bit_cnt_q == '0)) begin
            reload = 1'b1;
          end else if (!(CPHA && (bit_cnt_q == '0))) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = StWaitDesel;
    endcase

    if (reload) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = TX_IDLE;
        underrun_d = 1'b1;
      end
    end

    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
      state_q     <= StWaitDesel;
      settle_q    <= '0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      settle_q    <= settle_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign spi_miso_oe_o = (state_q == StActive);
  assign spi_miso_o    = (state_q == StActive) && tx_shift_q[DATA_W-1];
  assign tx_ready_o    = !hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign frame_abort_o = abort_q;

endmodule
